bgr_startup_ctrl: RTL and testbench
===================================

Name: bgr_startup_ctrl

Overview:
- Digital startup sequencer directly upstream of the bandgap top; its output drives the bandgap's porst input, which gates the startup NMOS that pulls the amplifier output node low.
- Pulses porst to kick the core out of the zero-current state, then waits for settling.
- Qualifies the bandgap-OK comparator output and reports ready, retrying or flagging a fault if the reference never comes up or later drops out.

Parameters:
- KICK_CYCLES, 8, cycles porst is held high per startup attempt (>=1)
- SETTLE_CYCLES, 64, wait after kick before checking vbg_ok; also the CHECK timeout (>=1)
- DEBOUNCE_CYCLES, 4, consecutive synchronized samples needed to accept or drop lock (>=1)
- MAX_RETRIES, 3, extra kick attempts after the first before FAULT
- CNT_W, 8, timer width; must hold max(KICK_CYCLES, SETTLE_CYCLES)

Ports:
- clk  in  1  sequencer clock
- rst_n  in  1  reset, asynchronous assert, active-low
- en  in  1  enable startup; level-sensitive
- vbg_ok  in  1  asynchronous comparator output, high when vbg is in window
- porst  out  1  startup kick to bandgap porst, active-high
- bgr_ready  out  1  reference qualified and stable
- fault  out  1  all attempts exhausted; sticky until en=0
- retry_cnt  out  2  number of retries used so far (saturates at MAX_RETRIES)

Behaviour:
- Reset (rst_n=0, async): state=IDLE; porst=0, bgr_ready=0, fault=0, retry_cnt=0; synchronizer flops, timer and debounce counter cleared.
- vbg_ok passes through a 2-flop synchronizer to give ok_s. All decisions use ok_s only. This adds 2 cycles of latency.
- All outputs are registered and Moore-decoded from the next state. porst rises the first cycle after en is sampled high.
- IDLE: outputs low. en=1 -> KICK; timer loads KICK_CYCLES.
- KICK: porst=1. Timer decrements each cycle. On expiry -> SETTLE; timer loads SETTLE_CYCLES.
- SETTLE: porst=0; ok_s ignored. On expiry -> CHECK; timer loads SETTLE_CYCLES; debounce counter=0.
- CHECK:
  - ok_s=1 increments the debounce counter; ok_s=0 clears it.
  - Counter reaching DEBOUNCE_CYCLES -> READY.
  - Timer expiry without reaching it: if retry_cnt==MAX_RETRIES -> FAULT; else retry_cnt+1 and go to KICK.
  - Debounce success takes priority over timeout in the same cycle.
- READY:
  - bgr_ready=1.
  - Debounce counter counts consecutive ok_s=0 and clears on ok_s=1.
  - Reaching DEBOUNCE_CYCLES -> KICK with bgr_ready=0 and retry_cnt cleared to 0 (lost-lock recovery is a fresh sequence).
- FAULT: fault=1, porst=0, bgr_ready=0. Held until en=0.
- en=0 in any state -> IDLE next cycle, overriding all other transitions. porst, bgr_ready, fault and retry_cnt clear in that same cycle. Deasserting en mid-kick ends the kick immediately.
- Reset mid-operation drops porst asynchronously. No partial state is retained.
- Timers never wrap: loads saturate at 2^CNT_W-1, and elaboration fails if a parameter exceeds the counter width.
- Illegal state encodings recover to IDLE.

Decomposition:
- Shared package bgr_pkg holds:
  - state enum (IDLE, KICK, SETTLE, CHECK, READY, FAULT)
  - default timing constants
  - retry counter width
- One sub-module, bgr_sync2: generic 2-flop synchronizer with async active-low reset, reusable for other analog status lines.

Test Plan:
- Nominal start: en=1 at cycle 0, vbg_ok=1 from cycle 0 -> porst high cycles 1-8, low thereafter; bgr_ready rises at cycle 77 (1+8+64+4); retry_cnt=0, fault=0.
- Single retry: vbg_ok=0 until the second settle window, then 1 -> exactly two porst pulses of 8 cycles each; retry_cnt=1; bgr_ready rises at cycle 77+136=213.
- Exhaustion: vbg_ok stuck 0 -> 4 porst pulses; retry_cnt reaches 3; fault=1 one cycle after the 4th CHECK timeout; porst stays 0; en=0 then clears fault next cycle.
- Glitch and lost lock: in READY, 3-cycle low pulse on vbg_ok -> bgr_ready stays 1. A 6-cycle low pulse -> bgr_ready drops and a new 8-cycle porst pulse starts, with retry_cnt=0.
- Abort: en=0 at cycle 4 (mid-kick) -> porst=0 at cycle 5, state IDLE. Re-enable -> full 8-cycle kick restarts.
- Async reset: rst_n low mid-SETTLE between clock edges -> all outputs 0 immediately without a clock edge. After release, nothing happens until en is sampled.

Source files
------------

// File: rtl/bgr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bgr_pkg
//  Brief    : Shared types and timing defaults for the bandgap startup sequencer.
//  Revision : 1.0
// ============================================================================
package bgr_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KICK   = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    READY  = 3'd4,
    FAULT  = 3'd5
  } bgr_state_e;

  localparam int unsigned DEF_KICK_CYCLES     = 8;
  localparam int unsigned DEF_SETTLE_CYCLES   = 64;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_MAX_RETRIES     = 3;
  localparam int unsigned DEF_CNT_W           = 8;
  localparam int unsigned RETRY_W             = 2;

  // Clamp a timer load so it can never wrap inside a WIDTH-bit counter.
  function automatic int unsigned sat_load(input int unsigned val, input int unsigned width);
    int unsigned lim;
    lim = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val > lim) ? lim : val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bgr_startup_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : bgr_startup_ctrl_if
//  Brief    : Control/status bundle between the system and the startup sequencer.
//  Revision : 1.0
// ============================================================================
interface bgr_startup_ctrl_if;
  import bgr_pkg::*;

  logic               en;
  logic               vbg_ok;
  logic               porst;
  logic               bgr_ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;

  modport slave  (input  en, vbg_ok, output porst, bgr_ready, fault, retry_cnt);
  modport master (output en, vbg_ok, input  porst, bgr_ready, fault, retry_cnt);

endinterface
`default_nettype wire

// File: rtl/bgr_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : bgr_sync2
//  Brief    : Generic 2-flop synchronizer for asynchronous analog status lines.
//  Revision : 1.0
// ============================================================================
module bgr_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  wire              clk,
  input  wire              rst_n,
  input  wire  [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/bgr_startup_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bgr_startup_ctrl
//  Brief    : Kicks the bandgap out of its zero-current state, qualifies vbg_ok,
//             retries on timeout and recovers from lost lock.
//  Revision : 1.0
// ============================================================================
module bgr_startup_ctrl
  import bgr_pkg::*;
#(
  parameter int unsigned KICK_CYCLES     = DEF_KICK_CYCLES,
  parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned MAX_RETRIES     = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  wire               clk,
  input  wire               rst_n,
  bgr_startup_ctrl_if.slave bus
);

  localparam int unsigned DEB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   KICK_LOAD   = CNT_W'(sat_load(KICK_CYCLES, CNT_W));
  localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(sat_load(SETTLE_CYCLES, CNT_W));
  localparam logic [DEB_W-1:0]   DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  if ((KICK_CYCLES < 1) || (SETTLE_CYCLES < 1) || (DEBOUNCE_CYCLES < 1) ||
      ((KICK_CYCLES >> CNT_W) != 0) || ((SETTLE_CYCLES >> CNT_W) != 0) ||
      ((MAX_RETRIES >> RETRY_W) != 0)) begin : g_bad_params
    $error("bgr_startup_ctrl: parameter out of range for counter widths");
  end

  bgr_state_e         state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [DEB_W-1:0]   deb_q,   deb_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               porst_q, porst_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;
  logic               ok_s;
  logic               expired;

  bgr_sync2 #(.WIDTH(1)) u_sync_ok (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.vbg_ok),
    .q_o   (ok_s)
  );

  assign expired = (timer_q <= CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      deb_q   <= '0;
      retry_q <= '0;
      porst_q <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      deb_q   <= deb_d;
      retry_q <= retry_d;
      porst_q <= porst_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    deb_d   = deb_q;
    retry_d = retry_q;
    if (!bus.en) begin
      state_d = IDLE;
      timer_d = '0;
      deb_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = KICK;
          timer_d = KICK_LOAD;
          deb_d   = '0;
          retry_d = '0;
        end
        KICK: begin
          if (expired) begin
            state_d = SETTLE;
            timer_d = SETTLE_LOAD;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        SETTLE: begin
          if (expired) begin
            state_d = CHECK;
            timer_d = SETTLE_LOAD;
            deb_d   = '0;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        CHECK: begin
          // A final qualifying sample wins over a timeout in the same cycle.
          if (ok_s && (deb_q == DEB_LAST)) begin
            state_d = READY;
            deb_d   = '0;
          end else if (expired) begin
            deb_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = FAULT;
            end else begin
              state_d = KICK;
              timer_d = KICK_LOAD;
              retry_d = retry_q + RETRY_W'(1);
            end
          end else begin
            timer_d = timer_q - CNT_W'(1);
            deb_d   = ok_s ? (deb_q + DEB_W'(1)) : '0;
          end
        end
        READY: begin
          // Lost lock restarts a fresh sequence with its own retry budget.
          if (!ok_s && (deb_q == DEB_LAST)) begin
            state_d = KICK;
            timer_d = KICK_LOAD;
            deb_d   = '0;
            retry_d = '0;
          end else begin
            deb_d = ok_s ? '0 : (deb_q + DEB_W'(1));
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
          deb_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    porst_d = (state_d == KICK);
    ready_d = (state_d == READY);
    fault_d = (state_d == FAULT);
  end

  assign bus.porst     = porst_q;
  assign bus.bgr_ready = ready_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_bgr_startup_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bgr_startup_ctrl
//  Brief    : Directed, table-driven checks of the bandgap startup sequencer.
//  Revision : 1.0
// ============================================================================
module tb_bgr_startup_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bgr_startup_ctrl_if bif ();

  bgr_startup_ctrl #(
    .KICK_CYCLES     (8),
    .SETTLE_CYCLES   (64),
    .DEBOUNCE_CYCLES (4),
    .MAX_RETRIES     (3),
    .CNT_W           (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  // Expected word layout: {porst, bgr_ready, fault, retry_cnt[1:0]}
  typedef struct {
    int         cyc;
    logic       en;
    logic       vbg;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_now  = 0;
  int   porst_cycles;

  task automatic add(input int c, input logic e, input logic v, input logic [4:0] x,
                     input string n);
    vecs.push_back('{cyc: c, en: e, vbg: v, exp: x, name: n});
  endtask

  task automatic check(input string name, input logic [4:0] exp, input int c);
    logic [4:0] act;
    act = {bif.porst, bif.bgr_ready, bif.fault, bif.retry_cnt};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: porst/rdy/flt/retry got %b want %b", name, c, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    bif.en     = 1'b0;
    bif.vbg_ok = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.en     = 1'b0;
    bif.vbg_ok = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", 5'b00000, 0);
    rst_n = 1'b1;
    @(negedge clk);
    cyc_now = 0;

    // Nominal start, glitch tolerance, lost lock, and mid-kick abort.
    add(0,   1, 1, 5'b00000, "idle_before_en");
    add(1,   1, 1, 5'b10000, "kick_first");
    add(8,   1, 1, 5'b10000, "kick_last");
    add(9,   1, 1, 5'b00000, "kick_end");
    add(76,  1, 1, 5'b00000, "pre_ready");
    add(77,  1, 1, 5'b01000, "ready_rise");
    add(90,  1, 0, 5'b01000, "glitch_start");
    add(93,  1, 1, 5'b01000, "glitch_end");
    add(100, 1, 1, 5'b01000, "glitch_survived");
    add(110, 1, 0, 5'b01000, "loss_start");
    add(115, 1, 0, 5'b01000, "loss_debouncing");
    add(116, 1, 1, 5'b10000, "loss_rekick");
    add(123, 1, 1, 5'b10000, "rekick_last");
    add(124, 1, 1, 5'b00000, "rekick_end");
    add(191, 1, 1, 5'b00000, "relock_pre_ready");
    add(192, 1, 1, 5'b01000, "relock_ready");
    add(200, 0, 1, 5'b01000, "disable_apply");
    add(201, 0, 1, 5'b00000, "disabled_idle");
    add(205, 1, 1, 5'b00000, "reenable");
    add(206, 1, 1, 5'b10000, "kick2_first");
    add(209, 0, 1, 5'b10000, "kick2_abort_apply");
    add(210, 0, 1, 5'b00000, "abort_porst_drop");
    add(212, 1, 1, 5'b00000, "restart_apply");
    add(213, 1, 1, 5'b10000, "restart_kick_first");
    add(220, 1, 1, 5'b10000, "restart_kick_last");
    add(221, 1, 1, 5'b00000, "restart_kick_end");

    foreach (vecs[i]) begin
      while (cyc_now < vecs[i].cyc) begin
        @(negedge clk);
        cyc_now++;
      end
      check(vecs[i].name, vecs[i].exp, cyc_now);
      bif.en     = vecs[i].en;
      bif.vbg_ok = vecs[i].vbg;
    end

    // Single retry: reference only appears during the second settle window.
    apply_reset();
    bif.en       = 1'b1;
    porst_cycles = 0;
    for (int c = 1; c <= 213; c++) begin
      @(negedge clk);
      if (bif.porst) porst_cycles++;
      if (c == 136) check("retry_first_check_end", 5'b00000, c);
      if (c == 137) check("retry_second_kick", 5'b10001, c);
      if (c == 212) check("retry_pre_ready", 5'b00001, c);
      if (c == 213) check("retry_ready", 5'b01001, c);
      if (c == 145) bif.vbg_ok = 1'b1;
    end
    check_int("retry_porst_cycles", porst_cycles, 16);

    // Exhaustion: vbg_ok stuck low.
    apply_reset();
    bif.en       = 1'b1;
    porst_cycles = 0;
    for (int c = 1; c <= 546; c++) begin
      @(negedge clk);
      if (bif.porst) porst_cycles++;
      if (c == 137) check("exh_retry1", 5'b10001, c);
      if (c == 273) check("exh_retry2", 5'b10010, c);
      if (c == 409) check("exh_retry3", 5'b10011, c);
      if (c == 544) check("exh_last_check", 5'b00011, c);
      if (c == 545) check("exh_fault", 5'b00111, c);
      if (c == 546) check("exh_fault_hold", 5'b00111, c);
    end
    check_int("exh_porst_cycles", porst_cycles, 32);
    bif.en = 1'b0;
    @(negedge clk);
    check("fault_cleared", 5'b00000, 547);

    // Asynchronous reset between clock edges, mid-kick and mid-settle.
    apply_reset();
    bif.en = 1'b1;
    for (int c = 1; c <= 140; c++) begin
      @(negedge clk);
      if (c == 140) check("pre_async_kick", 5'b10001, c);
    end
    #2 rst_n = 1'b0;
    #1 check("async_rst_kick", 5'b00000, 140);
    bif.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 5'b00000, 0);
    bif.en = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (c == 1)   check("post_rst_kick", 5'b10000, c);
      if (c == 150) check("pre_async_settle", 5'b00001, c);
    end
    #2 rst_n = 1'b0;
    #1 check("async_rst_settle", 5'b00000, 150);
    bif.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
